// File: rtl/stream_fifo_if.sv
// Handshake, data and status bundle for stream_fifo.
// The slave modport is the FIFO side; the master modport is its user.
interface stream_fifo_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count,
               full, empty, almost_full, almost_empty
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count,
               full, empty, almost_full, almost_empty
    );
endinterface

// File: rtl/stream_fifo.sv
// First-word fall-through stream FIFO with registered flags and head data.
// Define STREAM_FIFO_WATERMARK_EN to add the max_count high-water output.
module stream_fifo #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    stream_fifo_if.slave             bus
`ifdef STREAM_FIFO_WATERMARK_EN
    ,
    output logic [$clog2(DEPTH):0]   max_count
`endif
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    remain_c;
    logic [WIDTH-1:0] head_q, head_d;
    logic             full_q, empty_q, af_q, ae_q;
    logic             in_ready_q, out_valid_q;
    logic             push_c, pop_c;

    // Handshakes depend only on registered state, so out_ready never reaches in_ready.
    assign push_c = bus.in_valid && in_ready_q && !flush;
    assign pop_c  = out_valid_q && bus.out_ready && !flush;

    // Next pointers, occupancy and the head entry as it will look after this edge.
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        remain_c = count_q - CW'(pop_c);
        head_d   = '0;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_c) wptr_d = wptr_q + PW'(1);
            if (pop_c)  rptr_d = rptr_q + PW'(1);
            count_d = count_q + CW'(push_c) - CW'(pop_c);
            if (count_d != '0) begin
                // With nothing left after the pop, the new head is the word being written.
                head_d = (remain_c == '0) ? bus.in_data : mem_q[rptr_d];
            end
        end
    end

    // Storage is never reset.
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wptr_q] <= bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            head_q      <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            head_q      <= head_d;
            full_q      <= (count_d == CW'(DEPTH));
            empty_q     <= (count_d == '0);
            af_q        <= (count_d >= CW'(AF_LEVEL));
            ae_q        <= (count_d <= CW'(AE_LEVEL));
            in_ready_q  <= (count_d != CW'(DEPTH));
            out_valid_q <= (count_d != '0);
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = head_q;
    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;

`ifdef STREAM_FIFO_WATERMARK_EN
    logic [CW-1:0] max_q;

    // Tracks the registered count, so it follows a rise by one cycle; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_q <= '0;
        end else if (count_q > max_q) begin
            max_q <= count_q;
        end
    end

    assign max_count = max_q;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Directed self-checking bench for stream_fifo at WIDTH=64, DEPTH=8, default levels.
module tb_stream_fifo;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned DEPTH = 8;

    logic clk;
    logic rst_n;
    logic flush;
    int   n_checks;
    int   n_fail;

    stream_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

`ifdef STREAM_FIFO_WATERMARK_EN
    logic [3:0] max_count;
    stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .max_count(max_count));
`else
    stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_data   = '0;
        flush         = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.count); end
        n_checks++;
        if ({bus.empty, bus.full, bus.almost_empty, bus.almost_full} !== 4'b1010) begin
            n_fail++; $display("FAIL reset_flags got e%b f%b ae%b af%b want e1 f0 ae1 af0",
                               bus.empty, bus.full, bus.almost_empty, bus.almost_full);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 64'd0) begin
            n_fail++; $display("FAIL reset_hs got ov%b ir%b data %h want ov0 ir1 data 0",
                               bus.out_valid, bus.in_ready, bus.out_data);
        end
`ifdef STREAM_FIFO_WATERMARK_EN
        n_checks++;
        if (max_count !== 4'd0) begin n_fail++; $display("FAIL reset_max got %0d want 0", max_count); end
`endif
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 64'(i);
            tick();
            n_checks++;
            if (bus.count !== 4'(i) || bus.full !== (i == 8) || bus.in_ready !== (i != 8)
                || bus.almost_full !== (i >= 6) || bus.almost_empty !== (i <= 1)) begin
                n_fail++;
                $display("FAIL fill_%0d got cnt %0d f%b ir%b af%b ae%b", i, bus.count,
                         bus.full, bus.in_ready, bus.almost_full, bus.almost_empty);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 64'(i)) begin
                n_fail++; $display("FAIL drain_%0d got ov%b data %h want %h", i,
                                   bus.out_valid, bus.out_data, 64'(i));
            end
            tick();
        end
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.empty !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 64'd0) begin
            n_fail++; $display("FAIL drain_empty got e%b ov%b data %h want e1 ov0 data 0",
                               bus.empty, bus.out_valid, bus.out_data);
        end
`ifdef STREAM_FIFO_WATERMARK_EN
        n_checks++;
        if (max_count !== 4'd8) begin n_fail++; $display("FAIL fill_max got %0d want 8", max_count); end
`endif
    endtask

    task automatic test_latency();
        idle();
        n_checks++;
        if (bus.out_data !== 64'd0 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL lat_before got ov%b data %h want ov0 data 0", bus.out_valid, bus.out_data);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 64'hA5;
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hA5) begin
            n_fail++; $display("FAIL lat_after got ov%b data %h want ov1 data a5", bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.empty !== 1'b1 || bus.out_data !== 64'd0) begin
            n_fail++; $display("FAIL lat_pop got e%b data %h want e1 data 0", bus.empty, bus.out_data);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 64'(8'h10 + i);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.in_data = 64'(8'h14 + k);
            n_checks++;
            if (bus.out_data !== 64'(8'h10 + k)) begin
                n_fail++; $display("FAIL b2b_data_%0d got %h want %h", k, bus.out_data, 64'(8'h10 + k));
            end
            tick();
            n_checks++;
            if (bus.count !== 4'd4) begin
                n_fail++; $display("FAIL b2b_count_%0d got %0d want 4", k, bus.count);
            end
        end
        bus.in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (bus.out_data !== 64'(8'h24 + j)) begin
                n_fail++; $display("FAIL b2b_tail_%0d got %h want %h", j, bus.out_data, 64'(8'h24 + j));
            end
            tick();
        end
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty got %b want 1", bus.empty); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 64'(8'h20 + i);
            tick();
        end
        bus.in_data   = 64'h99;
        bus.out_ready = 1'b1;
        tick();
        n_checks++;
        if (bus.count !== 4'd7 || bus.out_data !== 64'h22 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL full_pp got cnt %0d data %h ir%b want cnt 7 data 22 ir1",
                               bus.count, bus.out_data, bus.in_ready);
        end
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.count !== 4'd8 || bus.full !== 1'b1) begin
            n_fail++; $display("FAIL full_repush got cnt %0d f%b want cnt 8 f1", bus.count, bus.full);
        end
        bus.out_ready = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            n_checks++;
            if (bus.out_data !== ((i == 9) ? 64'h99 : 64'(8'h20 + i))) begin
                n_fail++; $display("FAIL full_order_%0d got %h", i, bus.out_data);
            end
            tick();
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 64'(8'h40 + i);
            tick();
        end
        bus.out_ready = 1'b1;
        flush         = 1'b1;
        tick();
        idle();
        n_checks++;
        if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 64'd0) begin
            n_fail++; $display("FAIL flush got cnt %0d e%b ov%b data %h want cnt 0 e1 ov0 data 0",
                               bus.count, bus.empty, bus.out_valid, bus.out_data);
        end
`ifdef STREAM_FIFO_WATERMARK_EN
        n_checks++;
        if (max_count !== 4'd5) begin n_fail++; $display("FAIL flush_max got %0d want 5", max_count); end
`endif
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h77;
        tick();
        idle();
        n_checks++;
        if (bus.count !== 4'd1 || bus.out_data !== 64'h77) begin
            n_fail++; $display("FAIL flush_reuse got cnt %0d data %h want cnt 1 data 77", bus.count, bus.out_data);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 64'(8'h60 + i);
            tick();
        end
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        tick();
        rst_n = 1'b1;
        idle();
        n_checks++;
        if (bus.count !== 4'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 64'd0) begin
            n_fail++; $display("FAIL midrst got cnt %0d ov%b ir%b data %h want cnt 0 ov0 ir1 data 0",
                               bus.count, bus.out_valid, bus.in_ready, bus.out_data);
        end
`ifdef STREAM_FIFO_WATERMARK_EN
        n_checks++;
        if (max_count !== 4'd0) begin n_fail++; $display("FAIL midrst_max got %0d want 0", max_count); end
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle();
        #2;
        test_reset();
        test_fill_drain();
        test_latency();
        test_back_to_back();
        test_full_push_pop();
        test_flush();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning data bits per entry (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, meaning entry count; must be a power of 2 and >=2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, meaning the count at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 1, meaning the count at or below which almost_empty asserts.
REQ-005 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port flush  input  1  synchronous discard of all stored entries.
REQ-008 SHALL have port in_valid  input  1  producer offers in_data.
REQ-009 SHALL have port in_ready  output  1  FIFO accepts in_data.
REQ-010 SHALL have port in_data  input  WIDTH  write data.
REQ-011 SHALL have port out_valid  output  1  out_data holds the oldest entry.
REQ-012 SHALL have port out_ready  input  1  consumer takes out_data.
REQ-013 SHALL have port out_data  output  WIDTH  oldest entry (first-word fall-through).
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-015 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.

Function
REQ-016 SHALL push when in_valid && in_ready, writing in_data at the write pointer.
REQ-017 SHALL pop when out_valid && out_ready, advancing the read pointer.
REQ-018 SHALL drive in_ready = !full and out_valid = !empty, with no combinational path from out_ready to in_ready.
REQ-019 SHALL, when full, accept no push even if a pop occurs in the same cycle.
REQ-020 SHALL, when empty, pop nothing; a push in that cycle makes the entry visible on out_data the next cycle (1-cycle latency).
REQ-021 SHALL, on a simultaneous push and pop with 0<count<DEPTH, leave count unchanged.
REQ-022 SHALL implement read/write pointers as $clog2(DEPTH)-bit counters wrapping from DEPTH-1 to 0.
REQ-023 SHALL compute flags from the registered count: full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_LEVEL), almost_empty=(count<=AE_LEVEL).
REQ-024 SHALL drive out_data to all zeros while out_valid=0.
REQ-025 SHALL preserve FIFO order exactly; no entry is dropped or duplicated except by flush or reset.
REQ-026 SHALL, on flush=1, zero the pointers and count at the next edge, ignoring any push or pop that cycle; flush has priority over push and pop.

Reset
REQ-027 SHALL, when rst_n=0 at a rising edge, set pointers and count to 0, giving empty=1, full=0, almost_empty=1, almost_full=0, out_valid=0, out_data=0 and in_ready=1 after that edge.
REQ-028 SHALL take reset priority over flush, push and pop, including mid-stream; storage array contents are not reset.

Configuration
REQ-029 SHALL, with macro STREAM_FIFO_WATERMARK_EN defined, add output max_count (width of count) holding the highest count reached since reset; it resets to 0, is unaffected by flush, and updates in the cycle after count rises.
REQ-030 SHALL, without STREAM_FIFO_WATERMARK_EN, omit the max_count port and its logic entirely.

Verification (WIDTH=64, DEPTH=8, defaults)
REQ-031 SHALL cover: push 0x1..0x8 back-to-back -> in_ready=0 after 8th, full=1, count=8, almost_full from count=6; pop 8 -> out_data 0x1..0x8 in order, empty=1.
REQ-032 SHALL cover: empty FIFO, push 0xA5 -> out_valid=1 and out_data=0xA5 on next cycle; out_data=0 before.
REQ-033 SHALL cover: count=4, push and pop every cycle for 20 cycles -> count stays 4, pointers wrap, data order preserved.
REQ-034 SHALL cover: full FIFO, in_valid=1 and out_ready=1 same cycle -> one pop, no push, count=7, then push accepted next cycle.
REQ-035 SHALL cover: count=5, flush=1 with in_valid=1 and out_ready=1 -> count=0, empty=1 next cycle; with STREAM_FIFO_WATERMARK_EN, max_count stays 5.
REQ-036 SHALL cover: rst_n=0 asserted mid-stream at count=3 -> after the edge count=0, out_valid=0, in_ready=1, max_count=0.
